noc_credit_tx: RTL and testbench
================================

NOC_CREDIT_TX -- requirements
Module: noc_credit_tx

Interface
REQ-001 SHALL have parameter VC_W, default DEFAULT_VC_W, number of VCs (one bit per VC).
REQ-002 SHALL have parameter A_W, default DEFAULT_A_W, address width.
REQ-003 SHALL have parameter D_W, default DEFAULT_D_W, data width.
REQ-004 SHALL have parameter CREDITS, default 4, receiver buffer depth per VC (initial credits, >=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  PE offers a flit.
REQ-008 SHALL have port in_ready  output  1  flit accepted when in_valid&in_ready at clk edge.
REQ-009 SHALL have port in_vc  input  VC_W  one-hot target VC of offered flit.
REQ-010 SHALL have port in_data  input  D_W  flit data.
REQ-011 SHALL have port in_last  input  1  last flit of packet.
REQ-012 SHALL have port in_addr  input  A_W  destination address.
REQ-013 SHALL have port tx_vc_target  output  VC_W  one-hot VC being sent, 0 = idle.
REQ-014 SHALL have port tx_data  output  D_W  credit packet payload data.
REQ-015 SHALL have port tx_last  output  1  credit packet payload last.
REQ-016 SHALL have port tx_addr  output  A_W  credit packet routeinfo addr.
REQ-017 SHALL have port tx_credit_gnt  input  VC_W  receiver credit return, any number of bits set per cycle.

Function
REQ-018 SHALL hold one single-entry flit slot (data, last, addr, full flag) per VC.
REQ-019 SHALL drive in_ready = slot[in_vc] empty OR slot[in_vc] selected for send this cycle (combinational on in_vc and arbitration).
REQ-020 SHALL hold per-VC credit counter of width $clog2(CREDITS+1), reset to CREDITS.
REQ-021 SHALL treat a VC as eligible when its slot is full and its counter > 0.
REQ-022 SHALL select at most one eligible VC per cycle by round-robin, pointer advancing to one past the granted VC after each send.
REQ-023 SHALL register the selected flit into tx_* and set tx_vc_target one-hot at the next edge; tx_vc_target SHALL be 0 in any cycle following an edge with no send.
REQ-024 SHALL hold tx_data/tx_last/tx_addr at their previous values when tx_vc_target is 0.
REQ-025 SHALL give minimum latency: flit accepted at edge k appears on tx_vc_target during the cycle after edge k+1.
REQ-026 SHALL sustain one flit per cycle on a single VC with credits (slot drained and refilled in the same cycle).
REQ-027 SHALL decrement a VC counter at the edge its flit is loaded into tx_*, increment it at the edge tx_credit_gnt bit is sampled; simultaneous send and grant on one VC leaves it unchanged.
REQ-028 SHALL saturate a counter at CREDITS if a grant arrives when full, and flag an assertion failure under SIMULATION.
REQ-029 SHALL leave a VC with counter 0 ineligible; a grant at edge j makes it eligible for the send at edge j+1.
REQ-030 SHALL ignore in_vc when in_valid is 0; in_valid with non-one-hot in_vc SHALL fail an assertion under SIMULATION and accept nothing.

Reset
REQ-031 SHALL on rst clear all slot full flags, tx_vc_target=0, tx_data/tx_last/tx_addr=0, counters=CREDITS, RR pointer=VC 0, lock state cleared.
REQ-032 SHALL drop flits held in slots when rst asserts mid-packet; in_ready SHALL be 0 while rst is high.

Configuration
REQ-033 SHALL, with NOC_CREDIT_TX_PKT_LOCK_EN defined, keep arbitration locked on a VC after it sends a non-last flit until that VC sends its last flit (other VCs stall even if eligible).
REQ-034 SHALL, without NOC_CREDIT_TX_PKT_LOCK_EN, arbitrate per flit (flits of different VCs may interleave).

Verification
REQ-035 SHALL cover: reset, VC_W=2, CREDITS=4, 6 flits to VC0, no grants -> 4 flits sent with tx_vc_target=01, then idle, in_ready=0 with slot full.
REQ-036 SHALL cover: continuing, tx_credit_gnt=01 for 2 cycles -> flits 5 and 6 sent, each one cycle after its grant.
REQ-037 SHALL cover: both VCs full with credits, all flits last=1 -> tx_vc_target alternates 01,10,01,10.
REQ-038 SHALL cover: counter at 1, send and grant on same edge -> counter stays 1, next flit sent back-to-back.
REQ-039 SHALL cover: with NOC_CREDIT_TX_PKT_LOCK_EN, 3-flit packet on VC0 and VC1 pending -> VC0 flits contiguous, VC1 after VC0 last; without macro -> interleaved.
REQ-040 SHALL cover: rst asserted mid-packet with slots full -> next cycle tx_vc_target=0, counters=4, no stale flit sent after release.

Source files
------------

// File: rtl/noc_credit_tx.sv
// Credit-based NoC flit transmitter: one single-entry slot and one credit counter per VC, round-robin send.
// Optional NOC_CREDIT_TX_PKT_LOCK_EN holds arbitration on a VC from its first non-last flit through its last flit.
module noc_credit_tx #(
    parameter int unsigned VC_W    = 2,
    parameter int unsigned A_W     = 8,
    parameter int unsigned D_W     = 32,
    parameter int unsigned CREDITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [VC_W-1:0] in_vc,
    input  logic [D_W-1:0]  in_data,
    input  logic            in_last,
    input  logic [A_W-1:0]  in_addr,
    output logic [VC_W-1:0] tx_vc_target,
    output logic [D_W-1:0]  tx_data,
    output logic            tx_last,
    output logic [A_W-1:0]  tx_addr,
    input  logic [VC_W-1:0] tx_credit_gnt
);

    localparam int unsigned CNT_W = $clog2(CREDITS + 1);
    localparam int unsigned PTR_W = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

    logic [VC_W-1:0]  slot_full;
    logic [D_W-1:0]   slot_data [VC_W];
    logic [VC_W-1:0]  slot_last;
    logic [A_W-1:0]   slot_addr [VC_W];
    logic [CNT_W-1:0] credit_cnt [VC_W];
    logic [PTR_W-1:0] rr_ptr;

    logic [VC_W-1:0]  has_credit;
    logic [VC_W-1:0]  lock_mask;
    logic [VC_W-1:0]  elig;
    logic [VC_W-1:0]  sel_onehot;
    logic             sel_valid;
    logic [PTR_W-1:0] sel_idx;
    logic             in_vc_onehot;
    logic             accept;

    // Wrap base+off into the VC index range without a general modulo.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= VC_W) begin
            sum = sum - VC_W;
        end
        return PTR_W'(sum);
    endfunction

    always_comb begin
        has_credit = '0;
        for (int unsigned v = 0; v < VC_W; v++) begin
            has_credit[v] = (credit_cnt[v] != '0);
        end
    end

    assign elig = slot_full & has_credit & lock_mask;

    // Round-robin pick of the first eligible VC at or after rr_ptr.
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < VC_W; i++) begin
            if (!sel_valid && elig[rr_idx(rr_ptr, i)]) begin
                sel_valid = 1'b1;
                sel_idx   = rr_idx(rr_ptr, i);
            end
        end
        if (sel_valid) begin
            sel_onehot[sel_idx] = 1'b1;
        end
    end

    // A slot may take a new flit in the same cycle it is drained.
    assign in_vc_onehot = (in_vc != '0) && ((in_vc & (in_vc - VC_W'(1))) == '0);
    assign in_ready     = !rst && in_vc_onehot &&
                          (((in_vc & ~slot_full) != '0) || ((in_vc & sel_onehot) != '0));
    assign accept       = in_valid && in_ready;

`ifdef NOC_CREDIT_TX_PKT_LOCK_EN
    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

    lock_state_t     lock_state;
    lock_state_t     lock_state_nxt;
    logic [VC_W-1:0] lock_vc;
    logic            sel_last;

    assign sel_last = slot_last[sel_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= LK_OPEN;
        end else begin
            lock_state <= lock_state_nxt;
        end
    end

    always_comb begin
        lock_state_nxt = lock_state;
        case (lock_state)
            LK_OPEN: if (sel_valid && !sel_last) lock_state_nxt = LK_HELD;
            LK_HELD: if (sel_valid && sel_last)  lock_state_nxt = LK_OPEN;
            default: lock_state_nxt = LK_OPEN;
        endcase
    end

    always_comb begin
        lock_mask = '1;
        if (lock_state == LK_HELD) begin
            lock_mask = lock_vc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vc <= '0;
        end else if (sel_valid && !sel_last) begin
            lock_vc <= sel_onehot;
        end
    end
`else
    assign lock_mask = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
        end else begin
            for (int unsigned v = 0; v < VC_W; v++) begin
                if (accept && in_vc[v]) begin
                    slot_full[v] <= 1'b1;
                end else if (sel_onehot[v]) begin
                    slot_full[v] <= 1'b0;
                end
            end
        end
    end

    // Payload storage is qualified by slot_full, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < VC_W; v++) begin
            if (accept && in_vc[v]) begin
                slot_data[v] <= in_data;
                slot_last[v] <= in_last;
                slot_addr[v] <= in_addr;
            end
        end
    end

    // Send consumes a credit, grant returns one; both together cancel, grant at full saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < VC_W; v++) begin
                credit_cnt[v] <= CNT_MAX;
            end
        end else begin
            for (int unsigned v = 0; v < VC_W; v++) begin
                case ({sel_onehot[v], tx_credit_gnt[v]})
                    2'b10:   credit_cnt[v] <= credit_cnt[v] - CNT_W'(1);
                    2'b01:   if (credit_cnt[v] != CNT_MAX) credit_cnt[v] <= credit_cnt[v] + CNT_W'(1);
                    default: credit_cnt[v] <= credit_cnt[v];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_vc_target <= '0;
            tx_data      <= '0;
            tx_last      <= 1'b0;
            tx_addr      <= '0;
            rr_ptr       <= '0;
        end else begin
            tx_vc_target <= sel_onehot;
            if (sel_valid) begin
                tx_data <= slot_data[sel_idx];
                tx_last <= slot_last[sel_idx];
                tx_addr <= slot_addr[sel_idx];
                rr_ptr  <= rr_idx(sel_idx, 1);
            end
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!in_valid || in_vc_onehot);
            for (int unsigned v = 0; v < VC_W; v++) begin
                assert (!(tx_credit_gnt[v] && !sel_onehot[v] && (credit_cnt[v] == CNT_MAX)));
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_credit_tx.sv
// Scoreboard bench for noc_credit_tx: stimulus queues expected tx flits with their cycle, a monitor pops and compares.
module tb_noc_credit_tx;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_vc;
    logic [15:0] in_data;
    logic        in_last;
    logic [7:0]  in_addr;
    logic [1:0]  tx_vc_target;
    logic [15:0] tx_data;
    logic        tx_last;
    logic [7:0]  tx_addr;
    logic [1:0]  tx_credit_gnt;

    typedef struct {
        logic [1:0]  vc;
        logic [15:0] data;
        logic        last;
        logic [7:0]  addr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    noc_credit_tx #(.VC_W(2), .A_W(8), .D_W(16), .CREDITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vc        (in_vc),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_addr      (in_addr),
        .tx_vc_target (tx_vc_target),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_addr      (tx_addr),
        .tx_credit_gnt(tx_credit_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-idle tx cycle must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (tx_vc_target != 2'b00) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_tx: actual vc=%b data=%h last=%b addr=%h cyc=%0d, required no flit",
                         tx_vc_target, tx_data, tx_last, tx_addr, cyc);
            end else begin
                e = sb.pop_front();
                if (tx_vc_target !== e.vc || tx_data !== e.data || tx_last !== e.last ||
                    tx_addr !== e.addr || cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL tx_flit: actual vc=%b data=%h last=%b addr=%h cyc=%0d, required vc=%b data=%h last=%b addr=%h cyc=%0d",
                             tx_vc_target, tx_data, tx_last, tx_addr, cyc, e.vc, e.data, e.last, e.addr, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] vc, input logic [15:0] d, input logic l, input logic [7:0] a, input int c);
        exp_t e;
        e.vc = vc; e.data = d; e.last = l; e.addr = a; e.cyc = c;
        sb.push_back(e);
    endtask

    // Offer a flit, wait (bounded) for in_ready, and report the edge it was accepted on.
    task automatic send_flit(input logic [1:0] vc, input logic [15:0] d, input logic l, input logic [7:0] a,
                             output int acc);
        int n;
        in_valid = 1'b1; in_vc = vc; in_data = d; in_last = l; in_addr = a;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: actual in_ready=0 for vc=%b data=%h, required 1", vc, d);
        end
        tick();
        acc = cyc;
        in_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int g0;
        int h0;
        int k0;

        rst = 1'b1; in_valid = 1'b1; in_vc = 2'b01; in_data = '0; in_last = 1'b0; in_addr = '0;
        tx_credit_gnt = 2'b00;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_tx_vc", 32'(tx_vc_target), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_tx_last", 32'(tx_last), 0);
        check("rst_tx_addr", 32'(tx_addr), 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();

        // Six flits to VC0 with no grants: four go out back to back, the fifth parks, the sixth is refused.
        for (int i = 1; i <= 5; i++) begin
            send_flit(2'b01, 16'(16'hA000 + i), 1'b1, 8'(8'h10 + i), acc);
            if (i <= 4) push(2'b01, 16'(16'hA000 + i), 1'b1, 8'(8'h10 + i), acc + 1);
        end
        in_valid = 1'b1; in_vc = 2'b01; in_data = 16'hA006; in_last = 1'b1; in_addr = 8'h16;
        #1;
        check("stall_in_ready_0", 32'(in_ready), 0);
        tick();
        check("stall_in_ready_1", 32'(in_ready), 0);
        check("idle_tx_vc", 32'(tx_vc_target), 0);
        check("idle_tx_data_hold", 32'(tx_data), 32'h0000A004);
        tick();
        check("stall_in_ready_2", 32'(in_ready), 0);

        // Two single-cycle grants release flits 5 and 6, each one edge after its grant.
        g0 = cyc;
        tx_credit_gnt = 2'b01;
        push(2'b01, 16'hA005, 1'b1, 8'h15, g0 + 2);
        push(2'b01, 16'hA006, 1'b1, 8'h16, g0 + 3);
        tick();
        tick();
        in_valid = 1'b0; tx_credit_gnt = 2'b00;
        repeat (3) tick();

        // Drain VC1 credits, park one flit in each slot, then release both with alternating grants.
        for (int i = 1; i <= 4; i++) begin
            send_flit(2'b10, 16'(16'hB000 + i), 1'b1, 8'(8'h20 + i), acc);
            push(2'b10, 16'(16'hB000 + i), 1'b1, 8'(8'h20 + i), acc + 1);
        end
        send_flit(2'b10, 16'hC001, 1'b1, 8'h31, acc);
        send_flit(2'b01, 16'hC000, 1'b1, 8'h30, acc);
        h0 = cyc;
        push(2'b01, 16'hC000, 1'b1, 8'h30, h0 + 2);
        push(2'b10, 16'hC001, 1'b1, 8'h31, h0 + 3);
        push(2'b01, 16'hC002, 1'b1, 8'h32, h0 + 4);
        push(2'b10, 16'hC003, 1'b1, 8'h33, h0 + 5);
        in_valid = 1'b1; in_vc = 2'b01; in_data = 16'hC002; in_last = 1'b1; in_addr = 8'h32;
        tx_credit_gnt = 2'b11;
        #1;
        check("parked_in_ready", 32'(in_ready), 0);
        tick();
        check("granted_in_ready_vc0", 32'(in_ready), 1);
        tick();
        in_vc = 2'b10; in_data = 16'hC003; in_addr = 8'h33; tx_credit_gnt = 2'b00;
        #1;
        check("granted_in_ready_vc1", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        tx_credit_gnt = 2'b11;
        repeat (4) tick();
        tx_credit_gnt = 2'b00;
        repeat (2) tick();

        // Three-flit packet on VC0 with a VC1 flit pending mid-packet.
        k0 = cyc;
`ifdef NOC_CREDIT_TX_PKT_LOCK_EN
        push(2'b01, 16'hD000, 1'b0, 8'h40, k0 + 2);
        push(2'b01, 16'hD001, 1'b0, 8'h42, k0 + 4);
        push(2'b01, 16'hD002, 1'b1, 8'h43, k0 + 5);
        push(2'b10, 16'hD100, 1'b1, 8'h41, k0 + 6);
`else
        push(2'b01, 16'hD000, 1'b0, 8'h40, k0 + 2);
        push(2'b10, 16'hD100, 1'b1, 8'h41, k0 + 3);
        push(2'b01, 16'hD001, 1'b0, 8'h42, k0 + 4);
        push(2'b01, 16'hD002, 1'b1, 8'h43, k0 + 5);
`endif
        send_flit(2'b01, 16'hD000, 1'b0, 8'h40, acc);
        send_flit(2'b10, 16'hD100, 1'b1, 8'h41, acc);
        send_flit(2'b01, 16'hD001, 1'b0, 8'h42, acc);
        send_flit(2'b01, 16'hD002, 1'b1, 8'h43, acc);
        repeat (5) tick();

        // Reset mid-packet with both slots holding flits that must never appear.
        send_flit(2'b01, 16'hE000, 1'b0, 8'h50, acc);
        push(2'b01, 16'hE000, 1'b0, 8'h50, acc + 1);
        send_flit(2'b01, 16'hE001, 1'b0, 8'h51, acc);
        send_flit(2'b10, 16'hE002, 1'b1, 8'h52, acc);
        rst = 1'b1; in_valid = 1'b1; in_vc = 2'b01;
        #1;
        check("mid_rst_in_ready_0", 32'(in_ready), 0);
        tick();
        check("mid_rst_tx_vc", 32'(tx_vc_target), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_tx_last", 32'(tx_last), 0);
        check("mid_rst_tx_addr", 32'(tx_addr), 0);
        check("mid_rst_in_ready_1", 32'(in_ready), 0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) tick();

        // After release: VC1 is not locked out, and VC0 again has exactly four credits.
        send_flit(2'b10, 16'hF100, 1'b1, 8'h61, acc);
        push(2'b10, 16'hF100, 1'b1, 8'h61, acc + 1);
        for (int i = 1; i <= 5; i++) begin
            send_flit(2'b01, 16'(16'hF000 + i), 1'b1, 8'(8'h60 + i), acc);
            if (i <= 4) push(2'b01, 16'(16'hF000 + i), 1'b1, 8'(8'h60 + i), acc + 1);
        end
        repeat (6) tick();

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
